// File: rtl/ritc_delay_sequencer_if.sv
// ritc_delay_sequencer_if
// Groups the table-load port, the run handshake and the IDELAY register bus
// of the RITC delay sequencer.
//   tbl_wr_i/tbl_addr_i/tbl_dat_i : delay table write port (index 0-77, 6-bit tap)
//   start_i                       : single-cycle start pulse
//   busy_o/done_o/err_o           : run status
//   idl_addr_o/idl_dat_o/idl_wr_o : IDELAY register write bus (addr 0 ctrl, 1 delay)
//   idl_dat_i                     : IDELAY register readback, [5:0] = IDELAYCTRL ready
// The slave modport is the sequencer's view; master is the controlling side.
interface ritc_delay_sequencer_if;
    logic        tbl_wr_i;
    logic [6:0]  tbl_addr_i;
    logic [5:0]  tbl_dat_i;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        idl_addr_o;
    logic [31:0] idl_dat_o;
    logic        idl_wr_o;
    logic [31:0] idl_dat_i;

    modport master (
        output tbl_wr_i, tbl_addr_i, tbl_dat_i, start_i, idl_dat_i,
        input  busy_o, done_o, err_o, idl_addr_o, idl_dat_o, idl_wr_o
    );

    modport slave (
        input  tbl_wr_i, tbl_addr_i, tbl_dat_i, start_i, idl_dat_i,
        output busy_o, done_o, err_o, idl_addr_o, idl_dat_o, idl_wr_o
    );
endinterface

// File: rtl/ritc_delay_sequencer.sv
// ritc_delay_sequencer
// Resets the IDELAYCTRL, waits for it to report ready, then loads all 78
// IDELAY taps (2 RITCs x 3 channels x 13 bits, bit 12 = channel clock) from
// a local table, inserting SETTLE_CYCLES idle cycles after each delay write.
//   clk_i : single clock
//   rst_i : synchronous active-high reset (table contents are not reset)
//   seq   : ritc_delay_sequencer_if.slave (table port, start/status, IDELAY bus)
// RST_HOLD and RDY_TIMEOUT must be at least 1; SETTLE_CYCLES may be 0.
//
// state  | meaning
// IDLE   | waiting for start_i, table writable
// RST    | IDELAYCTRL reset write on addr 0
// HOLD   | RST_HOLD cycles after the reset write
// POLL   | waiting for readback [5:0] == 6'h3F, bounded by RDY_TIMEOUT
// FETCH  | table read for current entry
// WRITE  | delay write on addr 1
// SETTLE | SETTLE_CYCLES idle cycles, then advance entry
// DONE   | one-cycle done pulse
// ERR    | ready timeout, err_o set
module ritc_delay_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned RST_HOLD      = 32,
    parameter int unsigned RDY_TIMEOUT   = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    ritc_delay_sequencer_if.slave  seq
);
    localparam int unsigned TBL_DEPTH = 78;
    localparam int unsigned MAX_A     = (RST_HOLD > RDY_TIMEOUT) ? RST_HOLD : RDY_TIMEOUT;
    localparam int unsigned CNT_MAX   = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_HOLD, S_POLL, S_FETCH, S_WRITE, S_SETTLE, S_DONE, S_ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ritc;
    logic [1:0]       ch;
    logic [3:0]       bit_cnt;
    logic [5:0]       tbl [TBL_DEPTH];
    logic [6:0]       tbl_idx;
    logic             last_entry;
    logic             nxt_ritc;
    logic [1:0]       nxt_ch;
    logic [3:0]       nxt_bit;

    logic             busy;
    logic             done;
    logic             err;
    logic             idl_addr;
    logic [31:0]      idl_dat;
    logic             idl_wr;

    logic             unused_rdbk;
    assign unused_rdbk = ^seq.idl_dat_i[31:6];

    // Delay register layout; the channel clock (bit 12) uses bit field 4'hF.
    function automatic logic [31:0] delay_word(input logic [5:0] tap, input logic r,
                                               input logic [1:0] c, input logic [3:0] b);
        logic [3:0] bf;
        bf = (b == 4'd12) ? 4'hF : b;
        return {18'd0, r, 1'b1, c, bf, tap};
    endfunction

    assign tbl_idx    = (ritc ? 7'd39 : 7'd0) + 7'(ch) * 7'd13 + 7'(bit_cnt);
    assign last_entry = ritc && (ch == 2'd2) && (bit_cnt == 4'd12);

    // Entry order: bit innermost, then channel, then RITC.
    always_comb begin
        nxt_ritc = ritc;
        nxt_ch   = ch;
        nxt_bit  = bit_cnt + 4'd1;
        if (bit_cnt == 4'd12) begin
            nxt_bit = 4'd0;
            if (ch == 2'd2) begin
                nxt_ch   = 2'd0;
                nxt_ritc = ~ritc;
            end else begin
                nxt_ch = ch + 2'd1;
            end
        end
    end

    // Table is only writable while idle and is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && seq.tbl_wr_i && !busy && (seq.tbl_addr_i < 7'(TBL_DEPTH)))
            tbl[seq.tbl_addr_i] <= seq.tbl_dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ritc     <= 1'b0;
            ch       <= 2'd0;
            bit_cnt  <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            idl_addr <= 1'b0;
            idl_dat  <= 32'd0;
            idl_wr   <= 1'b0;
        end else begin
            idl_wr <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (seq.start_i) begin
                        state    <= S_RST;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        idl_addr <= 1'b0;
                        idl_dat  <= 32'h1;
                        idl_wr   <= 1'b1;
                    end
                end
                S_RST: begin
                    state <= S_HOLD;
                    cnt   <= CNT_W'(RST_HOLD - 1);
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_POLL;
                        cnt   <= CNT_W'(RDY_TIMEOUT - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_POLL: begin
                    if (seq.idl_dat_i[5:0] == 6'h3F) begin
                        state   <= S_FETCH;
                        ritc    <= 1'b0;
                        ch      <= 2'd0;
                        bit_cnt <= 4'd0;
                    end else if (cnt == '0) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // The output data register doubles as the registered table read.
                S_FETCH: begin
                    state    <= S_WRITE;
                    idl_addr <= 1'b1;
                    idl_wr   <= 1'b1;
                    idl_dat  <= delay_word(tbl[tbl_idx], ritc, ch, bit_cnt);
                end
                S_WRITE, S_SETTLE: begin
                    if ((state == S_WRITE) && (SETTLE_CYCLES != 0)) begin
                        state <= S_SETTLE;
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                    end else if ((state == S_SETTLE) && (cnt != '0)) begin
                        cnt <= cnt - 1'b1;
                    end else if (last_entry) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        idl_addr <= 1'b0;
                    end else begin
                        state   <= S_FETCH;
                        ritc    <= nxt_ritc;
                        ch      <= nxt_ch;
                        bit_cnt <= nxt_bit;
                    end
                end
                S_DONE, S_ERR: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    idl_addr <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign seq.busy_o     = busy;
    assign seq.done_o     = done;
    assign seq.err_o      = err;
    assign seq.idl_addr_o = idl_addr;
    assign seq.idl_dat_o  = idl_dat;
    assign seq.idl_wr_o   = idl_wr;
endmodule

// File: tb/tb_ritc_delay_sequencer.sv
// tb_ritc_delay_sequencer
// Two sequencer instances: A with default timing, B with SETTLE_CYCLES=0 and
// short hold/timeout. Expected write streams and timings come from a table
// model and the run-length arithmetic of the sequence.
module tb_ritc_delay_sequencer;
    localparam int A_SETTLE = 4, A_HOLD = 32, A_TO = 1024;
    localparam int B_SETTLE = 0, B_HOLD = 3,  B_TO = 8;

    typedef struct packed {
        logic        addr;
        logic [31:0] dat;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ritc_delay_sequencer_if ifa ();
    ritc_delay_sequencer_if ifb ();

    logic        start_v [2];
    logic        tw_v    [2];
    logic [6:0]  ta_v    [2];
    logic [5:0]  td_v    [2];
    logic [31:0] rdy_v   [2];
    int          tbl_m   [2][78];

    assign ifa.start_i    = start_v[0];
    assign ifa.tbl_wr_i   = tw_v[0];
    assign ifa.tbl_addr_i = ta_v[0];
    assign ifa.tbl_dat_i  = td_v[0];
    assign ifa.idl_dat_i  = rdy_v[0];
    assign ifb.start_i    = start_v[1];
    assign ifb.tbl_wr_i   = tw_v[1];
    assign ifb.tbl_addr_i = ta_v[1];
    assign ifb.tbl_dat_i  = td_v[1];
    assign ifb.idl_dat_i  = rdy_v[1];

    ritc_delay_sequencer #(.SETTLE_CYCLES(A_SETTLE), .RST_HOLD(A_HOLD), .RDY_TIMEOUT(A_TO))
        dut_a (.clk_i(clk), .rst_i(rst), .seq(ifa));
    ritc_delay_sequencer #(.SETTLE_CYCLES(B_SETTLE), .RST_HOLD(B_HOLD), .RDY_TIMEOUT(B_TO))
        dut_b (.clk_i(clk), .rst_i(rst), .seq(ifb));

    wr_t  wq0[$], wq1[$];
    int   dq0[$], dq1[$], eq0[$], eq1[$];
    logic err_p0 = 1'b0, err_p1 = 1'b0;

    always @(negedge clk) begin
        if (ifa.idl_wr_o) wq0.push_back({ifa.idl_addr_o, ifa.idl_dat_o, cyc});
        if (ifb.idl_wr_o) wq1.push_back({ifb.idl_addr_o, ifb.idl_dat_o, cyc});
        if (ifa.done_o) dq0.push_back(cyc);
        if (ifb.done_o) dq1.push_back(cyc);
        if (ifa.err_o && !err_p0) eq0.push_back(cyc);
        if (ifb.err_o && !err_p1) eq1.push_back(cyc);
        err_p0 = ifa.err_o;
        err_p1 = ifb.err_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int settle_of(input int w); return (w != 0) ? B_SETTLE : A_SETTLE; endfunction
    function automatic int hold_of(input int w);   return (w != 0) ? B_HOLD   : A_HOLD;   endfunction
    function automatic int to_of(input int w);     return (w != 0) ? B_TO     : A_TO;     endfunction

    function automatic logic [36:0] outs(input int w);
        if (w == 0)
            return {ifa.busy_o, ifa.done_o, ifa.err_o, ifa.idl_wr_o, ifa.idl_addr_o, ifa.idl_dat_o};
        return {ifb.busy_o, ifb.done_o, ifb.err_o, ifb.idl_wr_o, ifb.idl_addr_o, ifb.idl_dat_o};
    endfunction

    function automatic logic busy_of(input int w);
        return (w != 0) ? ifb.busy_o : ifa.busy_o;
    endfunction

    function automatic logic err_of(input int w);
        return (w != 0) ? ifb.err_o : ifa.err_o;
    endfunction

    // Expected delay word from the register layout.
    function automatic logic [31:0] exp_word(input int w, input int r, input int c, input int b);
        int v;
        v = tbl_m[w][r * 39 + c * 13 + b] + (((b == 12) ? 15 : b) * 64) + (c * 1024) + 4096 + (r * 8192);
        return 32'(v);
    endfunction

    // One table write; the model only takes it when the block is idle and in range.
    task automatic load(input int w, input int addr, input int val, input bit idle);
        tw_v[w] = 1'b1;
        ta_v[w] = 7'(addr);
        td_v[w] = 6'(val);
        @(negedge clk);
        tw_v[w] = 1'b0;
        if (idle && addr < 78) tbl_m[w][addr] = val;
    endtask

    task automatic run_seq(input int w, input int d, input bit ok);
        wr_t q[$];
        int  dqq[$], eqq[$];
        int  c, p, sp, t, k;
        if (w == 0) begin wq0.delete(); dq0.delete(); eq0.delete(); end
        else        begin wq1.delete(); dq1.delete(); eq1.delete(); end
        rdy_v[w] = ($urandom & 32'hFFFF_FFC0) | (ok ? 32'($urandom_range(0, 62)) : 32'h3E);
        start_v[w] = 1'b1;
        @(negedge clk);
        start_v[w] = 1'b0;
        c = cyc;
        if (ok) begin
            repeat (d) @(negedge clk);
            rdy_v[w][5:0] = 6'h3F;
        end
        t = 0;
        while (busy_of(w) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("run_ends", busy_of(w), 1'b0);
        @(negedge clk);
        if (w == 0) begin q = wq0; dqq = dq0; eqq = eq0; end
        else        begin q = wq1; dqq = dq1; eqq = eq1; end
        if (q.size() > 0) begin
            check_val("ctrl_wr", {q[0].addr, q[0].dat}, {1'b0, 32'h1});
            check_val("ctrl_cyc", q[0].cyc, c);
        end
        if (ok) begin
            p  = (d > hold_of(w) + 1) ? c + d : c + hold_of(w) + 1;
            sp = 2 + settle_of(w);
            check_val("wr_count", q.size(), 79);
            k = 0;
            for (int r = 0; r < 2; r++)
                for (int ch = 0; ch < 3; ch++)
                    for (int b = 0; b < 13; b++) begin
                        if (k + 1 < q.size()) begin
                            check_val("dly_wr", {q[k + 1].addr, q[k + 1].dat}, {1'b1, exp_word(w, r, ch, b)});
                            check_val("dly_cyc", q[k + 1].cyc, p + 2 + k * sp);
                        end
                        k++;
                    end
            check_val("done_cnt", dqq.size(), 1);
            if (dqq.size() > 0)
                check_val("done_cyc", dqq[0], p + 2 + 77 * sp + settle_of(w) + 1);
            check_val("err_clear", err_of(w), 1'b0);
        end else begin
            check_val("err_wr_count", q.size(), 1);
            check_val("err_rise_cnt", eqq.size(), 1);
            if (eqq.size() > 0)
                check_val("err_cyc", eqq[0], c + hold_of(w) + to_of(w) + 1);
            check_val("err_no_done", dqq.size(), 0);
            check_val("err_sticky", err_of(w), 1'b1);
        end
    endtask

    task automatic disturb();
        int t;
        repeat (60) @(negedge clk);
        start_v[0] = 1'b1;
        tw_v[0]    = 1'b1;
        ta_v[0]    = 7'd5;
        td_v[0]    = 6'(~tbl_m[0][5]);
        @(negedge clk);
        start_v[0] = 1'b0;
        tw_v[0]    = 1'b0;
        repeat (150) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        t = 0;
        while (!ifa.done_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_val("dist_done_seen", ifa.done_o, 1'b1);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
    endtask

    initial begin
        int t;
        rst = 1'b1;
        for (int w = 0; w < 2; w++) begin
            start_v[w] = 1'b0;
            tw_v[w]    = 1'b0;
            ta_v[w]    = 7'd0;
            td_v[w]    = 6'd0;
            rdy_v[w]   = 32'd0;
            for (int n = 0; n < 78; n++) tbl_m[w][n] = 0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_outs_a", outs(0), 37'd0);
        check_val("rst_outs_b", outs(1), 37'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_a", outs(0), 37'd0);
        check_val("post_rst_b", outs(1), 37'd0);

        for (int n = 0; n < 78; n++) load(0, n, n % 64, 1'b1);
        run_seq(0, 5, 1'b1);
        if (wq0.size() >= 79) begin
            check_val("entry0", wq0[1].dat, 32'h0000_1000);
            check_val("entry12", wq0[13].dat, 32'h0000_13CC);
            check_val("entry77", wq0[78].dat, 32'h0000_3BCD);
        end

        for (int n = 0; n < 78; n++) load(0, n, int'($urandom_range(0, 63)), 1'b1);
        run_seq(0, int'($urandom_range(1, 40)), 1'b1);

        load(0, 100, 63, 1'b1);
        load(0, 78, 63, 1'b1);
        load(0, 127, 0, 1'b1);
        run_seq(0, int'($urandom_range(1, 40)), 1'b1);

        fork
            run_seq(0, 10, 1'b1);
            disturb();
        join
        repeat (10) @(negedge clk);
        check_val("no_restart_busy", busy_of(0), 1'b0);
        check_val("no_restart_wr", wq0.size(), 79);

        wq0.delete();
        rst        = 1'b1;
        start_v[0] = 1'b1;
        tw_v[0]    = 1'b1;
        ta_v[0]    = 7'd7;
        td_v[0]    = 6'(~tbl_m[0][7]);
        @(negedge clk);
        rst        = 1'b0;
        start_v[0] = 1'b0;
        tw_v[0]    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_dom_outs", outs(0), 37'd0);
        check_val("rst_dom_wr", wq0.size(), 0);

        run_seq(0, 0, 1'b0);

        wq0.delete();
        rdy_v[0]   = 32'h3F;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        t = 0;
        while (wq0.size() < 42 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val("abort_reach", wq0.size(), 42);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_outs", outs(0), 37'd0);
        repeat (30) @(negedge clk);
        check_val("abort_no_wr", wq0.size(), 42);
        check_val("abort_idle", busy_of(0), 1'b0);
        run_seq(0, int'($urandom_range(1, 40)), 1'b1);

        for (int n = 0; n < 78; n++) load(1, n, int'($urandom_range(0, 63)), 1'b1);
        run_seq(1, int'($urandom_range(1, 8)), 1'b1);
        run_seq(1, 0, 1'b0);
        run_seq(1, int'($urandom_range(1, 8)), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
